// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU core front end.
package cpu_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      VALID = 1'b1
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] NOP                = 32'h0000_0000;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/npc_sel.sv
// Next-PC selection: jump > branch > sequential, with optional redirect
// alignment check enabled by PC_ALIGN_CHECK_EN.
module npc_sel
   import cpu_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
   input  logic [31:0] pc_plus4,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] npc,
   output logic        misaligned
);

   logic [31:0] target_s;
   logic        redirect_s;

   // Pick the redirect target; the jump keeps the PC's current 256 MB region
   always_comb begin
      target_s   = branch_target;
      redirect_s = jump | branch_taken;
      if (jump) begin
         target_s = {pc_plus4[31:28], jump_index, 2'b00};
      end else begin
         target_s = branch_target;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   // Misaligned redirects divert to the exception vector
   always_comb begin
      npc        = pc_plus4;
      misaligned = 1'b0;
      if (redirect_s && is_misaligned(target_s)) begin
         npc        = EXC_VECTOR;
         misaligned = 1'b1;
      end else if (redirect_s) begin
         npc        = target_s;
      end else begin
         npc        = pc_plus4;
      end
   end
`else
   logic [31:0] unused_exc_s;
   assign unused_exc_s = EXC_VECTOR;

   // Redirect targets are silently word-aligned
   always_comb begin
      npc        = pc_plus4;
      misaligned = 1'b0;
      if (redirect_s) begin
         npc = target_s & 32'hFFFF_FFFC;
      end else begin
         npc = pc_plus4;
      end
   end
`endif

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch handshake stage of the single-issue core.
// Optional redirect alignment check: PC_ALIGN_CHECK_EN (see npc_sel).
module pc_fetch
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        addr_err
);

   fetch_state_e state_r;
   fetch_state_e state_next_s;
   logic [31:0]  pc_r;
   logic [31:0]  instr_r;
   logic         valid_r;
   logic         addr_err_r;
   logic [31:0]  npc_s;
   logic         misaligned_s;
   logic         req_s;
   logic         accept_s;
   logic         capture_s;

   npc_sel #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_npc_sel (
      .pc_plus4      (pc_plus4),
      .jump          (jump),
      .jump_index    (jump_index),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .npc           (npc_s),
      .misaligned    (misaligned_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= FETCH;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         FETCH: begin
            if (imem_ready) state_next_s = VALID;
            else            state_next_s = FETCH;
         end
         VALID: begin
            if (stall) state_next_s = VALID;
            else       state_next_s = FETCH;
         end
         default: state_next_s = FETCH;
      endcase
   end

   // FSM outputs; the request is gated by reset so it drops immediately
   always_comb begin
      req_s     = 1'b0;
      accept_s  = 1'b0;
      capture_s = 1'b0;
      case (state_r)
         FETCH: begin
            req_s     = ~rst;
            capture_s = imem_ready;
         end
         VALID: begin
            accept_s = ~stall;
         end
         default: begin
            req_s = 1'b0;
         end
      endcase
   end

   // PC, instruction and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r       <= RESET_PC;
         instr_r    <= NOP;
         valid_r    <= 1'b0;
         addr_err_r <= 1'b0;
      end else begin
         addr_err_r <= 1'b0;
         if (capture_s) begin
            instr_r <= imem_rdata;
            valid_r <= 1'b1;
         end else if (accept_s) begin
            pc_r       <= npc_s;
            valid_r    <= 1'b0;
            addr_err_r <= misaligned_s;
         end
      end
   end

   assign pc          = pc_r;
   assign imem_addr   = pc_r;
   assign pc_plus4    = pc_r + 32'd4;
   assign imem_req    = req_s;
   assign instr       = instr_r;
   assign instr_valid = valid_r;
   assign addr_err    = addr_err_r;

endmodule
